uart_rx_os: RTL

- 16x-oversampling UART receiver with an integrated baud-tick generator driven by the shared `dvsr` divisor. Frame format: 8N1.
- Converts the serial `rx` line into parallel bytes with a one-cycle done strobe and a framing-error flag.
- Receive-side companion to the transmit path in the UART subsystem; instantiated inside `uart_top`. Its serial input is what an external transmitter drives.

---
 rtl/uart_rx_os.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x-oversampling 8N1 UART receiver with integrated baud-tick generator
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   dvsr         baud divisor; one oversample tick every dvsr+1 clk cycles
//   rx           asynchronous serial line, idle high
//   dout         last received data word (LSB received first)
//   rx_done_tick one-cycle strobe; dout/frame_err valid from this cycle on
//   frame_err    stop bit of the last frame sampled low; held until next done tick
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [10:0]     dvsr,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic            tick;
    logic            sync1_q, rx_s_q, rx_prev_q;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    // Free-running oversample tick; '>=' lets a reduced divisor wrap on the
    // next cycle instead of counting all the way round.
    always_comb begin
        tick  = (cnt_q >= dvsr);
        cnt_d = tick ? 11'd0 : cnt_q + 11'd1;
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Edge, not level: a line stuck low cannot start a new frame.
                if (!rx_s_q && rx_prev_q) begin
                    state_d = START;
                    s_d     = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = 4'd0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = 4'd0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_s_q;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 11'd0;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            s_q       <= 4'd0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule
